alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised WIDTH-bit sequential ALU. It replaces the per-bit ripple slice chain with a single registered datapath.
- Supports AND, OR, ADD, SUB, SLT, NOR and an iterative unsigned multiply.
- Uses a start/busy/done handshake.
- Sits between the decode stage and the register-file write port of the single-cycle/multi-cycle CPU labs.
- Single-cycle ops complete in one clock. MULU takes WIDTH clocks.

Parameters:
WIDTH, 32, operand and result width (≥4).
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
start_i  in  1  launch operation; sampled only when busy_o=0.
ctrl_i  in  4  op select: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULU; all others illegal.
src1_i  in  WIDTH  operand A.
src2_i  in  WIDTH  operand B.
busy_o  out  1  multiply in progress; start_i ignored.
done_o  out  1  one-cycle pulse: result/flags updated.
result_o  out  WIDTH  result; MULU low half.
result_hi_o  out  WIDTH  MULU high half; 0 for other ops.
zero_o  out  1  result_o (and result_hi_o for MULU) all zero.
cout_o  out  1  carry out, ADD/SUB only.
overflow_o  out  1  signed overflow, ADD/SUB only.

Behaviour:
Reset:
- rst_n=0 asynchronously forces state IDLE, counter 0, and all outputs 0.
- Reset mid-multiply aborts the operation. No done_o is produced.

FSM states: IDLE, MUL.
- IDLE → IDLE: start_i=1 with a single-cycle or illegal op.
- IDLE → MUL: start_i=1 with ctrl_i=MULU.
- MUL → IDLE: after the last iteration.

Single-cycle ops (start sampled at edge t0):
- result_o, flags and done_o=1 are registered at edge t0, so they are visible the cycle after the start.
- busy_o stays 0.
- Back-to-back starts every cycle are legal. done_o stays high across consecutive completions.

Arithmetic:
- ADD: src1+src2.
- SUB: src1+~src2+1; cout_o=1 means no borrow.
- overflow_o = carry into MSB XOR carry out of MSB.
- SLT: result = {0…0, sign(src1−src2) XOR overflow(src1−src2)}. It is correct across overflow, e.g. 0x80000000<1 gives 1.
- NOR: ~(src1|src2).
- cout_o and overflow_o are 0 for AND, OR, NOR, SLT and MULU.

MULU (unsigned shift-add):
- Edge t0 latches multiplicand and multiplier, clears the accumulator, sets counter=0 and busy_o=1.
- Edges t1…tWIDTH each do one iteration:
  - if the multiplier LSB is 1, add the multiplicand to the upper accumulator with a WIDTH+1 carry bit;
  - shift {carry,acc_hi,acc_lo} right by 1.
- At edge tWIDTH: result_hi_o/result_o = product, done_o=1, busy_o=0, state IDLE.
- Total latency is exactly WIDTH clocks from the start edge.
- Operands are latched at t0, so input changes during MUL have no effect.
- start_i while busy_o=1 is dropped, not queued.
- A new start is accepted on the cycle done_o is high.

Illegal ctrl_i:
- result_o=0, result_hi_o=0, zero_o=1, cout_o=0, overflow_o=0.
- done_o pulses after 1 cycle.

Output hold: outputs hold their last value until the next done_o. done_o is 0 in every cycle without a completion.

Decomposition:
- Package alu_pkg: ctrl opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MULU) and the state encoding (ST_IDLE, ST_MUL).
- Sub-module alu_core: purely combinational WIDTH-bit logic/add/sub/SLT unit producing result, cout and overflow. alu_seq instantiates it for single-cycle ops and owns the FSM, multiplier registers and output registers.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+0x00000001 → result 0x80000000, overflow_o=1, cout_o=0, zero_o=0, done_o exactly 1 cycle after start.
- SUB 5−5 → result 0, zero_o=1, cout_o=1, overflow_o=0. Then SLT 0x80000000,0x00000001 → 1. Then SLT 1,0x80000000 → 0. Issue these on consecutive cycles; done_o stays high 3 cycles.
- MULU 0xFFFFFFFF×0xFFFFFFFF → result_hi_o 0xFFFFFFFE, result_o 0x00000001. busy_o high 32 cycles; done_o on cycle 32. An ADD start at cycle 10 is ignored: one done only, product unaffected.
- MULU 0×0x1234 → zero_o=1. Pulse rst_n low at cycle 15 of a second MULU → outputs 0, busy_o=0, no done_o. A fresh start is accepted on the first clock after release.
- NOR 0,0 → 0xFFFFFFFF. Illegal ctrl 1111 → result 0, zero_o=1, done_o pulse.
- WIDTH=8 build: MULU 0xFF×0xFF → hi 0xFE, lo 0x01, done 8 cycles after start. ADD 0x80+0x80 → 0x00, cout_o=1, overflow_o=1, zero_o=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode and FSM state definitions shared by the sequential ALU and its combinational core.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_MULU = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational logic/add/sub/SLT unit; illegal or MULU opcodes yield all zeros.
// Latency: none (purely combinational).
// Backpressure: none; the caller decides when to sample.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             msb_cin;
  logic             ovf_raw;

  // SUB and SLT share the adder as src1 + ~src2 + 1.
  assign sub     = (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
  assign b_eff   = sub ? ~src2 : src2;
  assign sum     = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  // Carry into the MSB recovered from the MSB sum bit.
  assign msb_cin = src1[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
  assign ovf_raw = msb_cin ^ sum[WIDTH];

  always_comb begin
    result   = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (ctrl)
      ALU_AND: result = src1 & src2;
      ALU_OR:  result = src1 | src2;
      ALU_NOR: result = ~(src1 | src2);
      ALU_ADD, ALU_SUB: begin
        result   = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = ovf_raw;
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus a WIDTH-iteration shift-add unsigned multiply.
// Latency: 1 clock for single-cycle/illegal ops, WIDTH clocks for MULU.
// Backpressure: start_i is dropped while busy_o=1; nothing is queued.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH:0]     add_hi;
  logic [2*WIDTH-1:0] mul_next;

  logic [WIDTH-1:0]   core_result;
  logic               core_cout;
  logic               core_ovf;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .ctrl     (ctrl_i),
    .src1     (src1_i),
    .src2     (src2_i),
    .result   (core_result),
    .cout     (core_cout),
    .overflow (core_ovf)
  );

  // acc_lo starts as the multiplier; its LSB is consumed as product bits shift in from the top.
  assign add_hi   = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
  assign mul_next = {add_hi, acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      mcand       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      result_o    <= '0;
      result_hi_o <= '0;
      zero_o      <= 1'b0;
      cout_o      <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (ctrl_i == ALU_MULU) begin
              state  <= ST_MUL;
              busy_o <= 1'b1;
              cnt    <= '0;
              mcand  <= src1_i;
              acc_hi <= '0;
              acc_lo <= src2_i;
            end else begin
              // Illegal opcodes fall out of the core as zero result with clear flags.
              done_o      <= 1'b1;
              result_o    <= core_result;
              result_hi_o <= '0;
              zero_o      <= (core_result == '0);
              cout_o      <= core_cout;
              overflow_o  <= core_ovf;
            end
          end
        end
        ST_MUL: begin
          acc_hi <= mul_next[2*WIDTH-1:WIDTH];
          acc_lo <= mul_next[WIDTH-1:0];
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= ST_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            result_hi_o <= mul_next[2*WIDTH-1:WIDTH];
            result_o    <= mul_next[WIDTH-1:0];
            zero_o      <= (mul_next == '0);
            cout_o      <= 1'b0;
            overflow_o  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] src1, src2;
  logic        busy, done, zero, cout, ovf;
  logic [31:0] res, res_hi;

  logic        start8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, cout8, ovf8;
  logic [7:0]  res8, hi8;

  logic [66:0] obs, obs8;
  logic [66:0] exp_q[$];
  int          passed = 0;
  int          total  = 0;

  assign obs  = {res_hi, res, zero, cout, ovf};
  assign obs8 = {24'b0, hi8, 24'b0, res8, zero8, cout8, ovf8};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .ctrl_i(ctrl), .src1_i(src1), .src2_i(src2),
    .busy_o(busy), .done_o(done), .result_o(res), .result_hi_o(res_hi),
    .zero_o(zero), .cout_o(cout), .overflow_o(ovf)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .ctrl_i(ctrl8), .src1_i(a8), .src2_i(b8),
    .busy_o(busy8), .done_o(done8), .result_o(res8), .result_hi_o(hi8),
    .zero_o(zero8), .cout_o(cout8), .overflow_o(ovf8)
  );

  // Reference model: {hi, lo, zero, cout, overflow} for WIDTH=32.
  function automatic logic [66:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [63:0] p;
    logic [31:0] r, h;
    logic        c, v;
    h = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = {31'b0, ($signed(a) < $signed(b))};
      4'b1100: r = ~(a | b);
      4'b1000: begin p = 64'(a) * 64'(b); h = p[63:32]; r = p[31:0]; end
      default: ;
    endcase
    return {h, r, ({h, r} == 64'b0), c, v};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ctrl = '0; src1 = '0; src2 = '0;
    start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    total++; if ({obs, busy, done} !== 69'b0) $display("FAIL reset32: got %h want 0", {obs, busy, done}); else passed++;
    total++; if ({obs8, busy8, done8} !== 69'b0) $display("FAIL reset8: got %h want 0", {obs8, busy8, done8}); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    logic [66:0] e;
    start = 1'b1; ctrl = ALU_ADD; src1 = 32'h7FFF_FFFF; src2 = 32'h0000_0001;
    exp_q.push_back({32'h0, 32'h8000_0000, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL add_done: got %b want 1", done); else passed++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    total++; if (obs !== e) $display("FAIL add_ovf: got %h want %h", obs, e); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL add_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [66:0] e;
    logic [3:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    logic [66:0] xs [3];
    ops = '{ALU_SUB, ALU_SLT, ALU_SLT};
    as  = '{32'd5, 32'h8000_0000, 32'd1};
    bs  = '{32'd5, 32'd1, 32'h8000_0000};
    xs  = '{{64'h0, 3'b110}, {32'h0, 32'h1, 3'b000}, {64'h0, 3'b100}};
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; ctrl = ops[i]; src1 = as[i]; src2 = bs[i];
      exp_q.push_back(xs[i]);
      @(negedge clk);
      total++; if (done !== 1'b1) $display("FAIL b2b_done[%0d]: got %b want 1", i, done); else passed++;
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
      total++; if (obs !== e) $display("FAIL b2b_result[%0d]: got %h want %h", i, obs, e); else passed++;
    end
    start = 1'b0;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL b2b_end: got %b want 0", done); else passed++;
  endtask

  task automatic test_random_ops();
    logic [66:0] e;
    logic [3:0]  ops [6];
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
    for (int i = 0; i < 8; i++) begin
      start = 1'b1; ctrl = ops[$urandom_range(0, 5)]; src1 = $urandom; src2 = $urandom;
      if (i == 3) src2 = src1;
      exp_q.push_back(model(ctrl, src1, src2));
      @(negedge clk);
      total++; if (done !== 1'b1) $display("FAIL rand_done[%0d]: got %b want 1", i, done); else passed++;
      if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
      total++; if (obs !== e) $display("FAIL rand_result[%0d] op=%b: got %h want %h", i, ctrl, obs, e); else passed++;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mulu_drop();
    logic [66:0] e;
    int busy_cnt = 0, done_cnt = 0, done_cyc = -1;
    start = 1'b1; ctrl = ALU_MULU; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
    exp_q.push_back(model(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) begin src1 = 32'h3; src2 = 32'h7; end
      if (c == 10) begin start = 1'b1; ctrl = ALU_ADD; src1 = 32'h1; src2 = 32'h2; end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++; done_cyc = c;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        total++; if (obs !== e) $display("FAIL mulu_product: got %h want %h", obs, e); else passed++;
      end
    end
    total++; if (busy_cnt != 32) $display("FAIL mulu_busy_cycles: got %0d want 32", busy_cnt); else passed++;
    total++; if (done_cnt != 1) $display("FAIL mulu_done_count: got %0d want 1", done_cnt); else passed++;
    total++; if (done_cyc != 32) $display("FAIL mulu_latency: got %0d want 32", done_cyc); else passed++;
  endtask

  task automatic test_mulu_zero_reset();
    logic [66:0] e;
    int done_cnt = 0, stray = 0;
    start = 1'b1; ctrl = ALU_MULU; src1 = 32'h0; src2 = 32'h1234;
    exp_q.push_back({64'h0, 3'b100});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cnt++;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        total++; if (obs !== e) $display("FAIL mulu_zero: got %h want %h", obs, e); else passed++;
      end
    end
    total++; if (done_cnt != 1) $display("FAIL mulu_zero_done: got %0d want 1", done_cnt); else passed++;
    start = 1'b1; ctrl = ALU_MULU; src1 = 32'h3; src2 = 32'h5;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) stray++;
    end
    rst_n = 1'b0;
    #1;
    total++; if ({obs, busy, done} !== 69'b0) $display("FAIL abort_reset: got %h want 0", {obs, busy, done}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; ctrl = ALU_ADD; src1 = 32'd2; src2 = 32'd3;
    exp_q.push_back({32'h0, 32'h5, 3'b000});
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL restart_done: got %b want 1", done); else passed++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    total++; if (obs !== e) $display("FAIL restart_result: got %h want %h", obs, e); else passed++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) stray++;
    end
    total++; if (stray != 0) $display("FAIL abort_no_done: got %0d dones want 0", stray); else passed++;
  endtask

  task automatic test_nor_illegal();
    logic [66:0] e;
    start = 1'b1; ctrl = ALU_NOR; src1 = 32'h0; src2 = 32'h0;
    exp_q.push_back({32'h0, 32'hFFFF_FFFF, 3'b000});
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL nor_done: got %b want 1", done); else passed++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    total++; if (obs !== e) $display("FAIL nor_result: got %h want %h", obs, e); else passed++;
    start = 1'b1; ctrl = 4'b1111; src1 = 32'h7; src2 = 32'h9;
    exp_q.push_back({64'h0, 3'b100});
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL illegal_done: got %b want 1", done); else passed++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    total++; if (obs !== e) $display("FAIL illegal_result: got %h want %h", obs, e); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL illegal_pulse: got %b want 0", done); else passed++;
  endtask

  task automatic test_width8();
    logic [66:0] e;
    int done_cnt = 0, done_cyc = -1;
    start8 = 1'b1; ctrl8 = ALU_MULU; a8 = 8'hFF; b8 = 8'hFF;
    exp_q.push_back({24'b0, 8'hFE, 24'b0, 8'h01, 3'b000});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        done_cnt++; done_cyc = c;
        if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
        total++; if (obs8 !== e) $display("FAIL w8_mulu: got %h want %h", obs8, e); else passed++;
      end
    end
    total++; if (done_cnt != 1) $display("FAIL w8_mulu_done: got %0d want 1", done_cnt); else passed++;
    total++; if (done_cyc != 8) $display("FAIL w8_mulu_latency: got %0d want 8", done_cyc); else passed++;
    start8 = 1'b1; ctrl8 = ALU_ADD; a8 = 8'h80; b8 = 8'h80;
    exp_q.push_back({64'h0, 3'b111});
    @(negedge clk);
    start8 = 1'b0;
    total++; if (done8 !== 1'b1) $display("FAIL w8_add_done: got %b want 1", done8); else passed++;
    if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
    total++; if (obs8 !== e) $display("FAIL w8_add: got %h want %h", obs8, e); else passed++;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_random_ops();
    test_mulu_drop();
    test_mulu_zero_reset();
    test_nor_illegal();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
